// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pair of a 4:1 mux; grant held until the owner releases.
// Optional forced rotation after MAX_HOLD grant cycles when MUX4_ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       s1,
   output logic       s0,
   output logic       busy
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("MAX_HOLD must be in 2..255");
   end

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_n;
   logic [1:0] last, last_n;
   logic [1:0] owner, owner_n;
   logic [3:0] gnt_n;
   logic [1:0] sel_n;
   logic       load_en;
   logic [1:0] load_idx;
   logic [2:0] win;

`ifdef MUX4_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
   logic [7:0] hold_cnt, hold_cnt_n;
   logic [2:0] win_other;
   logic [3:0] others;
`endif

   // Returns {found, index}: first set bit of r scanning start, start+1, ... modulo 4.
   function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
      logic [1:0] idx;
      pick = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (r[idx]) pick = {1'b1, idx};
      end
   endfunction

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_n  = state;
      last_n   = last;
      owner_n  = owner;
      gnt_n    = gnt;
      sel_n    = {s1, s0};
      load_en  = 1'b0;
      load_idx = owner;
      win      = 3'b000;
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_cnt_n = hold_cnt;
      others     = req & ~(4'b0001 << owner);
      win_other  = pick(others, owner + 2'd1);
`endif
      unique case (state)
         IDLE: begin
            win = pick(req, last + 2'd1);
            if (win[2]) begin
               load_en  = 1'b1;
               load_idx = win[1:0];
            end
         end
         GRANT: begin
            if (!req[owner]) begin
               win = pick(req, owner + 2'd1);
               if (win[2]) begin
                  load_en  = 1'b1;
                  load_idx = win[1:0];
               end else begin
                  state_n = IDLE;
                  gnt_n   = 4'b0000;
               end
`ifdef MUX4_ARB_TIMEOUT_EN
            end else if (hold_cnt == HOLD_LIMIT) begin
               // Saturate at the limit so a late competitor is served on its first cycle.
               if (win_other[2]) begin
                  load_en  = 1'b1;
                  load_idx = win_other[1:0];
               end
            end else begin
               hold_cnt_n = hold_cnt + 8'd1;
`endif
            end
         end
         default: state_n = IDLE;
      endcase

      if (load_en) begin
         state_n = GRANT;
         owner_n = load_idx;
         last_n  = load_idx;
         gnt_n   = 4'b0001 << load_idx;
         sel_n   = load_idx;
`ifdef MUX4_ARB_TIMEOUT_EN
         hold_cnt_n = 8'd0;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last  <= 2'd3;
         owner <= 2'd0;
         gnt   <= 4'b0000;
         s1    <= 1'b0;
         s0    <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
         hold_cnt <= 8'd0;
`endif
      end else begin
         state <= state_n;
         last  <= last_n;
         owner <= owner_n;
         gnt   <= gnt_n;
         s1    <= sel_n[1];
         s0    <= sel_n[0];
`ifdef MUX4_ARB_TIMEOUT_EN
         hold_cnt <= hold_cnt_n;
`endif
      end
   end

   assign busy = |gnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed request vectors push expected outputs,
// a monitor pops and compares one entry per clock.
module tb_mux4_rr_arbiter;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       s1, s0, busy;

   int checks   = 0;
   int failures = 0;
   exp_t exp_q[$];
   bit   done = 1'b0;

`ifdef MUX4_ARB_TIMEOUT_EN
   localparam int unsigned HOLD = 4;
`else
   localparam int unsigned HOLD = 8;
`endif

   mux4_rr_arbiter #(.MAX_HOLD(HOLD)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .gnt  (gnt),
      .s1   (s1),
      .s0   (s0),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got gnt/sel/busy=%b_%b_%b want %b_%b_%b at %0t",
                  name, act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0], $time);
      end
   endtask

   // Drive req before the next rising edge and queue the outputs expected after it.
   task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es);
      exp_t e;
      @(negedge clk);
      req    = r;
      e.gnt  = eg;
      e.sel  = es;
      e.busy = (eg != 4'b0000);
      exp_q.push_back(e);
   endtask

   // Monitor: one comparison per clock while expectations are pending.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", {gnt, s1, s0, busy}, e);
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      #12;
      check("reset_state", {gnt, s1, s0, busy}, 7'b0000_00_0);
      @(negedge clk);
      rst = 1'b0;

      // All requesting: rotate 0,1,2,3 as each owner drops.
      step(4'b1111, 4'b0001, 2'b00);
      step(4'b1111, 4'b0001, 2'b00);
      step(4'b1110, 4'b0010, 2'b01);
      step(4'b1110, 4'b0010, 2'b01);
      step(4'b1100, 4'b0100, 2'b10);
      step(4'b1000, 4'b1000, 2'b11);
      step(4'b1000, 4'b1000, 2'b11);
      step(4'b0000, 4'b0000, 2'b11);

      // Owner 2 releases while 0 and 3 pend: 3 wins back-to-back.
      step(4'b0100, 4'b0100, 2'b10);
      step(4'b1101, 4'b0100, 2'b10);
      step(4'b1001, 4'b1000, 2'b11);
      step(4'b0000, 4'b0000, 2'b11);

      // Three-cycle pulse on req[2]; select holds 10 once idle.
      step(4'b0100, 4'b0100, 2'b10);
      step(4'b0100, 4'b0100, 2'b10);
      step(4'b0100, 4'b0100, 2'b10);
      step(4'b0000, 4'b0000, 2'b10);
      step(4'b0000, 4'b0000, 2'b10);

      // last=2: index 3 first, then wrap to 0; release plus new next request hands over.
      step(4'b1011, 4'b1000, 2'b11);
      step(4'b0011, 4'b0001, 2'b00);
      step(4'b0010, 4'b0010, 2'b01);
      step(4'b0101, 4'b0100, 2'b10);
      step(4'b0001, 4'b0001, 2'b00);
      step(4'b0000, 4'b0000, 2'b00);

      // Async reset mid-grant.
      step(4'b0010, 4'b0010, 2'b01);
      step(4'b0010, 4'b0010, 2'b01);
      drain();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_reset", {gnt, s1, s0, busy}, 7'b0000_00_0);
      req = 4'b0110;
      @(posedge clk);
      #1;
      check("reset_held", {gnt, s1, s0, busy}, 7'b0000_00_0);
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0000;
      step(4'b0110, 4'b0010, 2'b01);
      step(4'b0100, 4'b0100, 2'b10);
      step(4'b0000, 4'b0000, 2'b10);
      drain();

`ifdef MUX4_ARB_TIMEOUT_EN
      // Forced rotation every 4 cycles between two persistent requesters.
      for (int k = 0; k < 4; k++) step(4'b0011, 4'b0001, 2'b00);
      for (int k = 0; k < 4; k++) step(4'b0011, 4'b0010, 2'b01);
      for (int k = 0; k < 4; k++) step(4'b0011, 4'b0001, 2'b00);
      // Lone requester keeps the grant past the limit.
      for (int k = 0; k < 20; k++) step(4'b1000, 4'b1000, 2'b11);
`else
      // Without the timeout the owner keeps the grant indefinitely.
      for (int k = 0; k < 12; k++) step(4'b0011, 4'b0001, 2'b00);
      step(4'b0010, 4'b0010, 2'b01);
`endif
      step(4'b0000, 4'b0000, (HOLD == 4) ? 2'b11 : 2'b01);
      drain();

      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      if (!done) begin
         $display("FAIL watchdog: got no completion want finish before 200000");
         $fatal(1, "watchdog");
      end
   end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4:1 multiplexer between four requesters. It registers a one-hot grant and drives the mux select pair `s1`/`s0` so that the granted requester's input reaches the mux output. The grant is held until the owner releases its request. It sits directly in front of the 4:1 mux; `s1`/`s0` connect straight to the mux select inputs.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before forced rotation. Used only when `MUX4_ARB_TIMEOUT_EN` is defined. Legal range 2..255.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  4  request vector; bit n corresponds to mux input n.
- `gnt`  output  4  registered one-hot grant, or all-zero when idle.
- `s1`  output  1  mux select MSB; registered, equals the granted index bit 1.
- `s0`  output  1  mux select LSB; registered, equals the granted index bit 0.
- `busy`  output  1  high while any grant is active; equals `|gnt`.

## Operation
- State machine: IDLE, GRANT.
- Internal state:
  - `last[1:0]`: index of the most recent owner.
  - `owner[1:0]`: index of the current owner.
  - Hold counter, only when the timeout feature is compiled in.
- Priority order for each arbitration: `last+1`, `last+2`, `last+3`, `last`, all mod 4, wrapping 3→0. The first index with its `req` bit set wins.
- IDLE:
  - If `req==0`, stay in IDLE.
  - Otherwise arbitrate, load `owner`/`last` with the winner, set `gnt`/`s1`/`s0`, and move to GRANT.
- GRANT while `req[owner]==1`: hold `gnt`, `s1` and `s0` unchanged.
- GRANT when `req[owner]==0` (release):
  - Arbitrate among the remaining requesters starting at `owner+1`.
  - If there is a winner, hand over in the same edge (back-to-back, no idle cycle).
  - If there is none, go to IDLE with `gnt=0`.
- In IDLE, `s1`/`s0` keep their last granted value; the mux output is don't-care while `busy=0`.
- A requester that re-raises `req` while others are pending waits its round-robin turn.
- Simultaneous release by the owner and a new request from the next index: the new request wins on that edge.
- `gnt` is always one-hot or zero. `s1`/`s0` always match the index of the set bit in `gnt`.

## Timing
- Reset values:
  - `gnt=4'b0000`, `s1=0`, `s0=0`, `busy=0`.
  - State IDLE.
  - `last=3`, so `req[0]` has highest priority after reset.
  - Hold counter 0.
- Reset asserted mid-grant clears all of the above immediately, without waiting for a clock edge. Arbitration resumes at the first rising edge after `rst` falls.
- Request-to-grant latency from IDLE: `req` seen high at edge k gives `gnt` at edge k (registered output, valid for cycle k+1).
- Release-to-handover latency: `req[owner]` seen low at edge k gives the new `gnt` at edge k.
- No combinational path from `req` to any output.

## Configuration
- Macro `MUX4_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each GRANT cycle.
  - When it reaches `MAX_HOLD-1`, if any other `req` bit is set, the grant rotates to the next winner even though `req[owner]` is still high.
  - If no other requester is pending, the counter saturates and the owner keeps the grant.
- Undefined:
  - No counter is present.
  - The owner keeps the grant for as long as `req[owner]` stays high (starvation is possible by design).

## Test plan
- Reset then `req=4'b1111` held → grants rotate 0001 (held until `req[0]` drops), then 0010, 0100, 1000 as each owner drops its request; `s1s0` follows as 00, 01, 10, 11.
- Owner 2 granted; `req[2]` drops while `req=4'b1001` → next `gnt=4'b1000`, `s1s0=11`, on the same edge with no idle cycle between grants.
- Single `req=4'b0100` pulse for 3 cycles then 0 → `gnt=0100` for 3 cycles, then `gnt=0000`, `busy=0`, and `s1s0` stays 10.
- Assert `rst` while `gnt=0010` → outputs go to zero before the next clock edge; after release with `req=4'b0110`, the first grant is `0010` (`last=3` gives index 1 priority over 2).
- `MUX4_ARB_TIMEOUT_EN`, `MAX_HOLD=4`: `req=4'b0011` held → `gnt` 0001 for 4 cycles, then 0010 for 4 cycles, alternating.
- `MUX4_ARB_TIMEOUT_EN`, `MAX_HOLD=4`: only `req[3]` held for 20 cycles → `gnt=1000` for all 20 cycles.
